// File: rtl/elixirchip_es1_spu_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined multiplier among NUM_REQ requesters,
// with burst lock on s_last and an ID tag pipeline that routes results back.
module elixirchip_es1_spu_mul_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ID_BITS      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int S_DATA0_BITS = 8,
    parameter int S_DATA1_BITS = 8,
    parameter int M_DATA_BITS  = 64,
    parameter int MUL_LATENCY  = 3
) (
    input  logic                              reset,
    input  logic                              clk,
    input  logic                              cke,
    input  logic [NUM_REQ*S_DATA0_BITS-1:0]   s_data0,
    input  logic [NUM_REQ*S_DATA1_BITS-1:0]   s_data1,
    input  logic [NUM_REQ-1:0]                s_clear,
    input  logic [NUM_REQ-1:0]                s_last,
    input  logic [NUM_REQ-1:0]                s_valid,
    output logic [NUM_REQ-1:0]                s_ready,
    output logic [S_DATA0_BITS-1:0]           mul_data0,
    output logic [S_DATA1_BITS-1:0]           mul_data1,
    output logic                              mul_clear,
    output logic                              mul_valid,
    input  logic [M_DATA_BITS-1:0]            mul_result,
    output logic [M_DATA_BITS-1:0]            m_data,
    output logic [ID_BITS-1:0]                m_id,
    output logic [NUM_REQ-1:0]                m_valid
);

    typedef enum logic [0:0] {
        ST_ARB   = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [ID_BITS-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_BITS-1:0]   owner_q, owner_d;
    logic                 tag_vld_q [MUL_LATENCY];
    logic [ID_BITS-1:0]   tag_id_q  [MUL_LATENCY];

    logic [ID_BITS-1:0]   grant_s;
    logic                 found_s;
    logic                 accept_s;

    // Grant selection: locked owner during a burst, otherwise rotate from rr_ptr
    always_comb begin
        int idx;
        found_s = 1'b0;
        grant_s = '0;
        idx     = 0;
        if (state_q == ST_BURST) begin
            found_s = s_valid[owner_q];
            grant_s = owner_q;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (int'(rr_ptr_q) + k) % NUM_REQ;
                if (!found_s && s_valid[idx]) begin
                    found_s = 1'b1;
                    grant_s = idx[ID_BITS-1:0];
                end else begin
                    found_s = found_s;
                end
            end
        end
    end

    assign accept_s  = cke && !reset && found_s;
    assign mul_valid = accept_s;
    assign mul_data0 = s_data0[int'(grant_s)*S_DATA0_BITS +: S_DATA0_BITS];
    assign mul_data1 = s_data1[int'(grant_s)*S_DATA1_BITS +: S_DATA1_BITS];
    assign mul_clear = s_clear[grant_s];
    assign m_data    = mul_result;
    assign m_id      = tag_vld_q[MUL_LATENCY-1] ? tag_id_q[MUL_LATENCY-1] : '0;

    // One-hot ready to the granted requester and one-hot result strobe to the originator
    always_comb begin
        s_ready = '0;
        m_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            s_ready[i] = accept_s && (grant_s == ID_BITS'(i));
            m_valid[i] = tag_vld_q[MUL_LATENCY-1] && (tag_id_q[MUL_LATENCY-1] == ID_BITS'(i));
        end
    end

    // Next-state: advance rr_ptr past every accepted requester, lock on a non-last beat
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        if (accept_s) begin
            rr_ptr_d = (grant_s == ID_BITS'(NUM_REQ - 1)) ? '0 : grant_s + ID_BITS'(1);
            if (state_q == ST_ARB) begin
                if (!s_last[grant_s]) begin
                    state_d = ST_BURST;
                    owner_d = grant_s;
                end else begin
                    state_d = ST_ARB;
                end
            end else begin
                state_d = s_last[grant_s] ? ST_ARB : ST_BURST;
            end
        end else begin
            state_d = state_q;
        end
    end

    // State registers and tag pipeline; the tags advance in step with the enabled multiplier
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_ARB;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            for (int i = 0; i < MUL_LATENCY; i++) begin
                tag_vld_q[i] <= 1'b0;
                tag_id_q[i]  <= '0;
            end
        end else if (cke) begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            tag_vld_q[0] <= accept_s;
            tag_id_q[0]  <= grant_s;
            for (int i = 1; i < MUL_LATENCY; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_id_q[i]  <= tag_id_q[i-1];
            end
        end
    end

endmodule
